dmem_port_arbiter: RTL and testbench

Shares the single data-memory port between the pipeline memory stage and one auxiliary word-access master (debug/DMA).
- The pipeline has priority by default.
- A starvation counter forces an aux grant after STARVE_LIMIT denied cycles. On that cycle the arbiter stalls the pipeline.
- Sits between the memory stage outputs (address, store data, byte write mask, load flag) and the dmem macro.
- Dmem read is combinational; write commits at posedge clk.

---
 rtl/dmem_port_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: pipeline memory stage vs. one aux word master, with starvation-forced aux grants.
// Optional grant/stall statistics counters are compiled in with DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  input  logic [3:0]  p_we,
  input  logic        p_re,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_we,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_we,
  input  logic [31:0] dmem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_aux_gnt,
  output logic [15:0] stat_forced
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             p_act;
  logic             force_gnt;
  logic             aux_gnt;
  logic             unused_a_addr_lsb;

  // Aux addresses are word aligned; the low bits are dropped on the way to dmem.
  assign unused_a_addr_lsb = ^a_addr[1:0];

  assign p_act     = p_re | (|p_we);
  assign force_gnt = a_req & (wait_cnt == LIMIT);
  assign aux_gnt   = ~rst & a_req & (~p_act | force_gnt);

  // Port mux and handshake; reads are combinational so load data passes straight through.
  always_comb begin
    a_ack      = aux_gnt;
    p_stall    = p_act & aux_gnt;
    p_rdata    = dmem_rdata;
    dmem_addr  = p_addr;
    dmem_wdata = p_wdata;
    dmem_we    = rst ? 4'b0000 : p_we;
    if (aux_gnt) begin
      dmem_addr  = {a_addr[31:2], 2'b00};
      dmem_wdata = a_wdata;
      dmem_we    = a_we;
    end
  end

  // Starvation counter: counts consecutive denied aux request cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst || aux_gnt || !a_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Aux read response, one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
    end else begin
      a_rvalid <= aux_gnt & (a_we == 4'b0000);
      if (aux_gnt && (a_we == 4'b0000)) begin
        a_rdata <= dmem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating grant and pipeline-stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_aux_gnt <= '0;
      stat_forced  <= '0;
    end else begin
      if (aux_gnt && (stat_aux_gnt != 16'hFFFF)) begin
        stat_aux_gnt <= stat_aux_gnt + 16'd1;
      end
      if (p_stall && (stat_forced != 16'hFFFF)) begin
        stat_forced <= stat_forced + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a default instance with a dmem model and a STARVE_LIMIT=0 instance.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_we;
  logic        p_re;
  logic        a_req;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_we;

  logic [31:0] p_rdata, a_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        p_stall, a_ack, a_rvalid;
  logic [3:0]  dmem_we;

  logic [31:0] z_p_rdata, z_a_rdata, z_dmem_addr, z_dmem_wdata;
  logic [31:0] z_dmem_rdata = 32'h0000_0000;
  logic        z_p_stall, z_a_ack, z_a_rvalid;
  logic [3:0]  z_dmem_we;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_aux_gnt, stat_forced, z_stat_aux_gnt, z_stat_forced;
`endif

  logic [31:0] mem [0:255];
  int compares = 0;
  int errs     = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_we(p_we), .p_re(p_re),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_aux_gnt(stat_aux_gnt), .stat_forced(stat_forced)
`endif
  );

  dmem_port_arbiter #(.STARVE_LIMIT(0), .CNT_W(3)) dut_z (
    .clk(clk), .rst(rst),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_we(p_we), .p_re(p_re),
    .p_rdata(z_p_rdata), .p_stall(z_p_stall),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
    .a_ack(z_a_ack), .a_rvalid(z_a_rvalid), .a_rdata(z_a_rdata),
    .dmem_addr(z_dmem_addr), .dmem_wdata(z_dmem_wdata), .dmem_we(z_dmem_we),
    .dmem_rdata(z_dmem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_aux_gnt(z_stat_aux_gnt), .stat_forced(z_stat_forced)
`endif
  );

  // Dmem model: combinational read, byte-masked write on posedge.
  assign dmem_rdata = mem[dmem_addr[9:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dmem_we[b]) mem[dmem_addr[9:2]][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEAD_BEEF;
    rst = 1'b1; p_addr = 32'h0; p_wdata = 32'h0; p_we = 4'h0; p_re = 1'b0;
    a_req = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_we = 4'h0;
    tick(); tick();

    // Reset: writes and grants suppressed, address follows the pipeline
    p_addr = 32'h55; p_we = 4'hF; a_req = 1'b1; a_we = 4'hF;
    #1;
    chk("rst_dmem_we", 32'(dmem_we), 32'h0);
    chk("rst_a_ack", 32'(a_ack), 32'h0);
    chk("rst_p_stall", 32'(p_stall), 32'h0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h55);
    chk("rst_z_a_ack", 32'(z_a_ack), 32'h0);
    p_we = 4'h0; a_req = 1'b0; a_we = 4'h0; p_addr = 32'h0;
    tick();
    rst = 1'b0;
    tick();

    // Idle-slot aux read
    a_req = 1'b1; a_we = 4'h0; a_addr = 32'h103;
    #1;
    chk("idle_a_ack", 32'(a_ack), 32'h1);
    chk("idle_dmem_addr", dmem_addr, 32'h100);
    chk("idle_p_stall", 32'(p_stall), 32'h0);
    chk("idle_dmem_we", 32'(dmem_we), 32'h0);
    tick();
    a_req = 1'b0;
    #1;
    chk("idle_a_rvalid", 32'(a_rvalid), 32'h1);
    chk("idle_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("idle_p_stall2", 32'(p_stall), 32'h0);
    chk("idle_a_ack2", 32'(a_ack), 32'h0);
    tick();
    chk("idle_rvalid_drop", 32'(a_rvalid), 32'h0);
    chk("idle_rdata_hold", a_rdata, 32'hDEAD_BEEF);

    // Starvation under continuous pipeline loads; limit-0 instance grants every cycle
    p_re = 1'b1; p_addr = 32'h200; a_req = 1'b1; a_we = 4'h0; a_addr = 32'h100; a_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_ack_%0d", i), 32'(a_ack), ((i % 5) == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve_stall_%0d", i), 32'(p_stall), ((i % 5) == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve_addr_%0d", i), dmem_addr, ((i % 5) == 4) ? 32'h100 : 32'h200);
      chk($sformatf("starve_rvalid_%0d", i), 32'(a_rvalid), ((i % 5) == 0 && i > 0) ? 32'h1 : 32'h0);
      chk($sformatf("z_ack_%0d", i), 32'(z_a_ack), 32'h1);
      chk($sformatf("z_stall_%0d", i), 32'(z_p_stall), 32'h1);
      chk($sformatf("z_addr_%0d", i), z_dmem_addr, 32'h100);
      chk($sformatf("z_rvalid_%0d", i), 32'(z_a_rvalid), (i > 0) ? 32'h1 : 32'h0);
      tick();
    end
    chk("starve_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("z_dmem_we", 32'(z_dmem_we), 32'h0);
    chk("z_p_rdata", z_p_rdata, 32'h0);

    // Pipe byte store collides with aux write: pipe first, aux next idle cycle
    p_re = 1'b0; p_we = 4'b0100; p_addr = 32'h22; p_wdata = 32'hAAAA_AAAA;
    a_req = 1'b1; a_we = 4'hF; a_addr = 32'h40; a_wdata = 32'h1234_5678;
    #1;
    chk("col_a_ack", 32'(a_ack), 32'h0);
    chk("col_dmem_we", 32'(dmem_we), 32'h4);
    chk("col_dmem_addr", dmem_addr, 32'h22);
    tick();
    p_we = 4'h0;
    #1;
    chk("aw_a_ack", 32'(a_ack), 32'h1);
    chk("aw_dmem_we", 32'(dmem_we), 32'hF);
    chk("aw_dmem_addr", dmem_addr, 32'h40);
    chk("aw_dmem_wdata", dmem_wdata, 32'h1234_5678);
    chk("aw_p_stall", 32'(p_stall), 32'h0);
    tick();
    a_req = 1'b0;
    #1;
    chk("aw_rvalid", 32'(a_rvalid), 32'h0);
    chk("mem_sb", mem[8'h08], 32'h00AA_0000);
    chk("mem_aw", mem[8'h10], 32'h1234_5678);

    // Read back the aux write
    a_req = 1'b1; a_we = 4'h0; a_addr = 32'h42;
    #1;
    chk("rb_a_ack", 32'(a_ack), 32'h1);
    chk("rb_dmem_addr", dmem_addr, 32'h40);
    tick();
    a_req = 1'b0;
    #1;
    chk("rb_rvalid", 32'(a_rvalid), 32'h1);
    chk("rb_rdata", a_rdata, 32'h1234_5678);
    tick();

    // Reset right after an aux read grant
    a_req = 1'b1; a_we = 4'h0; a_addr = 32'h100;
    #1;
    chk("rg_a_ack", 32'(a_ack), 32'h1);
    tick();
    rst = 1'b1; p_we = 4'hF; p_addr = 32'h30; p_wdata = 32'hFFFF_FFFF;
    #1;
    chk("rg_dmem_we", 32'(dmem_we), 32'h0);
    chk("rg_a_ack2", 32'(a_ack), 32'h0);
    chk("rg_p_stall", 32'(p_stall), 32'h0);
    tick();
    chk("rg_rvalid", 32'(a_rvalid), 32'h0);
    chk("rg_rdata", a_rdata, 32'h0);
    chk("rg_mem_untouched", mem[8'h0C], 32'h0);
    rst = 1'b0; p_we = 4'h0; p_re = 1'b1; p_addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("post_rst_ack_%0d", i), 32'(a_ack), (i == 4) ? 32'h1 : 32'h0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule
